point_mapper: RTL
=================

# point_mapper

Downstream consumer of the point writer's output. It accepts one point at a time (`xval`, `yval`, `pvalid`) and acknowledges it with a one-cycle `done_point` pulse, which advances the point writer's counters. Each point is rasterised as a two-pixel-wide dot (`xval`, `xval+1`) into the pixel framebuffer over a req/ack write port. It also keeps a saturating count of points drawn.

## Interface
Parameters:
- `CLEAR_COLOR`, default 4'd0: pixel value written by the frame-clear sweep.

Ports:
- `clock` in 1: single system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `pvalid` in 1: point on `xval`/`yval` is valid and held stable until `done_point`.
- `xval` in 8: doubled x coordinate (even values, 0..254).
- `yval` in 6: y coordinate 0..63.
- `color` in 4: pixel value; sampled with the point.
- `done_point` out 1: one-cycle pulse acknowledging the captured point.
- `mem_req` out 1: write request, held until accepted.
- `mem_ack` in 1: memory accepts the write in any cycle where `mem_req & mem_ack`; may be combinational from `mem_req`.
- `mem_addr` out 14: `{y, x}` pixel address.
- `mem_wdata` out 4: pixel value.
- `busy` out 1: high in any state other than IDLE.
- `points_written` out 16: count of completed points; saturates at 16'hFFFF.
- `clear_req` in 1: request a full-frame clear (only with `POINT_MAPPER_CLEAR_EN`).
- `clear_done` out 1: one-cycle pulse at end of the sweep (only with `POINT_MAPPER_CLEAR_EN`).

## Operation
- FSM states: IDLE, WR0, WR1, CLR. CLR is present only with the macro defined.
- IDLE, `pvalid=1` (and no pending clear):
  - Latch `xval`, `yval`, `color`.
  - Go to WR0.
  - Register `done_point=1` for the first WR0 cycle only.
- WR0:
  - `mem_req=1`, `mem_addr={y, x}`, `mem_wdata=c`.
  - On `mem_ack`, go to WR1.
- WR1:
  - `mem_req=1`, `mem_addr={y, x+1}` (`x+1` is 8-bit; `x=254` gives 255, with no wrap since x is even).
  - On `mem_ack`, increment `points_written` (hold at FFFF) and return to IDLE.
- No new point is captured outside IDLE. A `pvalid` that stays high after `done_point` describes the next point and is captured on the next IDLE cycle.
- `pvalid=0` in IDLE: remain in IDLE; `xval`/`yval` are ignored, including zero values.
- `mem_addr` and `mem_wdata` hold their last values when `mem_req=0`.
- Reset mid-write: `mem_req` drops asynchronously. The captured point is discarded and is not counted.

## Timing
- Reset values:
  - `done_point=0`, `mem_req=0`, `mem_addr=0`, `mem_wdata=0`.
  - `busy=0`, `points_written=0`, `clear_done=0`.
  - FSM in IDLE, clear pending flag = 0.
- Minimum point cost is 3 cycles: capture (IDLE), WR0 with immediate ack, WR1 with immediate ack. A new capture can occur in the cycle after WR1 completes.
- `done_point` is high exactly in the first WR0 cycle, so the point writer advances at that cycle's closing edge.
- Each `mem_wait` cycle (`mem_req=1`, `mem_ack=0`) adds one cycle. Address and data are stable throughout.

## Configuration
- `POINT_MAPPER_CLEAR_EN` defined:
  - A `clear_req` pulse sets a pending flag; pulses during an existing pending or sweep are absorbed.
  - In IDLE, a pending clear has priority over `pvalid`: enter CLR and clear the flag.
  - CLR writes `CLEAR_COLOR` to addresses 0..16383 in order, one per ack.
  - After the ack for address 16383: pulse `clear_done` for 1 cycle and return to IDLE.
  - `points_written` is unaffected.
  - Reset mid-sweep aborts the sweep with no `clear_done`.
- Undefined:
  - `clear_req` is ignored and `clear_done` is tied to 0.
  - No CLR state exists.

## Test plan
- Single point, ack always high:
  - Stimulus: `xval=8'd20`, `yval=6'd5`, `color=4'd9`, `pvalid=1`.
  - Response: `done_point` is a single pulse on cycle 1. Writes go to 14'h0514 then 14'h0515, both with data 9. `points_written=1`. `busy` returns low on cycle 3.
- Ack stall:
  - Stimulus: `mem_ack` held low 4 cycles in WR0.
  - Response: `mem_addr` and `mem_wdata` are stable, there is no second `done_point`, and the point completes in 7 cycles.
- Back-to-back:
  - Stimulus: `pvalid` held high for a horizontal edge x=0,2,4 at y=63.
  - Response: six writes to 14'h3F00..14'h3F05, three `done_point` pulses spaced 3 cycles apart.
- Right-boundary point:
  - Stimulus: `xval=254`, `yval=0`.
  - Response: writes go to 14'h00FE and 14'h00FF.
- Reset during WR1:
  - Response: `mem_req` goes low before the next edge and `points_written` is unchanged. A fresh point after reset is written normally.
- With `POINT_MAPPER_CLEAR_EN`:
  - Stimulus: `clear_req` and `pvalid` asserted in the same IDLE cycle.
  - Response: 16384 writes of 0 occur first, then `clear_done`, then the point is captured and acked.

Source files
------------

// File: rtl/point_mapper.sv
// Rasterises each accepted point as a two-pixel dot into the framebuffer.
// Optional full-frame clear sweep enabled by defining POINT_MAPPER_CLEAR_EN.
module point_mapper #(
  parameter logic [3:0] CLEAR_COLOR = 4'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pvalid,
  input  logic [7:0]  xval,
  input  logic [5:0]  yval,
  input  logic [3:0]  color,
  output logic        done_point,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [13:0] mem_addr,
  output logic [3:0]  mem_wdata,
  output logic        busy,
  output logic [15:0] points_written,
  input  logic        clear_req,
  output logic        clear_done
);

  localparam int unsigned AW = 14;
  localparam logic [AW-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE,
    WR0,
    WR1
`ifdef POINT_MAPPER_CLEAR_EN
    , CLR
`endif
  } state_t;

  state_t        state, state_n;
  logic          done_n, req_n, busy_n, cdone_n;
  logic [AW-1:0] addr_n;
  logic [3:0]    wdata_n;
  logic [15:0]   pw_n;
  logic          clear_go;

`ifdef POINT_MAPPER_CLEAR_EN
  logic pending, pending_n;

  // A request arriving in the same IDLE cycle as a point still wins.
  assign clear_go = pending | clear_req;

  always_comb begin
    pending_n = pending;
    if (state == IDLE && clear_go)
      pending_n = 1'b0;
    else if (clear_req && state != CLR)
      pending_n = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending    <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      pending    <= pending_n;
      clear_done <= cdone_n;
    end
  end
`else
  logic unused_clear;
  assign unused_clear = clear_req | (|CLEAR_COLOR);
  assign clear_go     = 1'b0;
  assign clear_done   = 1'b0;
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    req_n   = 1'b0;
    cdone_n = 1'b0;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    pw_n    = points_written;
    case (state)
      IDLE: begin
        if (clear_go) begin
`ifdef POINT_MAPPER_CLEAR_EN
          state_n = CLR;
          req_n   = 1'b1;
          addr_n  = '0;
          wdata_n = CLEAR_COLOR;
`endif
        end else if (pvalid) begin
          state_n = WR0;
          done_n  = 1'b1;
          req_n   = 1'b1;
          addr_n  = {yval, xval};
          wdata_n = color;
        end
      end
      WR0: begin
        req_n = 1'b1;
        if (mem_ack) begin
          state_n = WR1;
          addr_n  = {mem_addr[13:8], 8'(mem_addr[7:0] + 8'd1)};
        end
      end
      WR1: begin
        if (mem_ack) begin
          state_n = IDLE;
          if (points_written != 16'hFFFF)
            pw_n = 16'(points_written + 16'd1);
        end else begin
          req_n = 1'b1;
        end
      end
`ifdef POINT_MAPPER_CLEAR_EN
      CLR: begin
        req_n = 1'b1;
        if (mem_ack) begin
          if (mem_addr == LAST_ADDR) begin
            state_n = IDLE;
            req_n   = 1'b0;
            cdone_n = 1'b1;
          end else begin
            addr_n = AW'(mem_addr + AW'(1));
          end
        end
      end
`endif
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      done_point     <= 1'b0;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      busy           <= 1'b0;
      points_written <= '0;
    end else begin
      state          <= state_n;
      done_point     <= done_n;
      mem_req        <= req_n;
      mem_addr       <= addr_n;
      mem_wdata      <= wdata_n;
      busy           <= busy_n;
      points_written <= pw_n;
    end
  end

endmodule
